// File: rtl/ct_vfdsu_mlane_iter_if.sv
// Issue / writeback bundle of the multi-lane VFDSU divide/sqrt iteration engine.
// master = ex1/ex4 side driving operands and ack, slave = the engine.
interface ct_vfdsu_mlane_iter_if #(
   parameter int WIDTH = 53,
   parameter int LANES = 2
);
   localparam int QW = WIDTH + 2;

   logic                   in_vld;
   logic                   in_rdy;
   logic                   in_sqrt;
   logic [LANES-1:0]       in_lane_en;
   logic [LANES-1:0]       in_odd;
   logic [LANES*WIDTH-1:0] in_src_a;
   logic [LANES*WIDTH-1:0] in_src_b;
   logic                   out_vld;
   logic                   out_ack;
   logic [LANES*QW-1:0]    out_quo;
   logic [LANES-1:0]       out_sticky;
   logic                   busy;

   modport master (
      output in_vld, in_sqrt, in_lane_en, in_odd, in_src_a, in_src_b, out_ack,
      input  in_rdy, out_vld, out_quo, out_sticky, busy
   );

   modport slave (
      input  in_vld, in_sqrt, in_lane_en, in_odd, in_src_a, in_src_b, out_ack,
      output in_rdy, out_vld, out_quo, out_sticky, busy
   );
endinterface

// File: rtl/ct_vfdsu_mlane_iter.sv
// Lock-step radix-2 restoring divide / square-root iteration over LANES mantissa lanes.
// Define CT_VFDSU_EARLY_TERM_EN to leave ITER as soon as every active lane's remainder is exhausted.
module ct_vfdsu_mlane_iter #(
   parameter int WIDTH = 53,
   parameter int LANES = 2
) (
   input logic                  forever_cpuclk,
   input logic                  cpurst_b,
   input logic                  rtu_yy_xx_flush,
   ct_vfdsu_mlane_iter_if.slave io
);
   localparam int QW = WIDTH + 2;
   localparam int RW = QW + 3;
   localparam int CW = $clog2(QW);
   localparam logic [CW-1:0] LAST = CW'(QW - 1);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   // opnd holds the divisor for divide, or the not-yet-consumed radicand bits for sqrt
   typedef struct packed {
      logic [RW-1:0] rem;
      logic [QW-1:0] opnd;
      logic [QW-1:0] quo;
   } lane_t;

   function automatic lane_t lane_step(input logic sqrt, input lane_t cur);
      lane_t           nxt;
      logic [RW-1:0]   sh;
      logic [RW-1:0]   trial;
      logic [WIDTH+1:0] dvd;
      logic [WIDTH+1:0] dvs;
      logic [WIDTH+1:0] diff;
      logic            ge;
      nxt = cur;
      if (sqrt) begin
         sh       = {cur.rem[RW-3:0], cur.opnd[QW-1 -: 2]};
         trial    = {1'b0, cur.quo, 2'b01};
         ge       = sh >= trial;
         nxt.rem  = ge ? sh - trial : sh;
         nxt.opnd = {cur.opnd[QW-3:0], 2'b00};
      end else begin
         dvd     = cur.rem[WIDTH+1:0];
         dvs     = {2'b00, cur.opnd[WIDTH-1:0]};
         ge      = dvd >= dvs;
         diff    = ge ? dvd - dvs : dvd;
         nxt.rem = {2'b00, diff, 1'b0};
      end
      nxt.quo = {cur.quo[QW-2:0], ge};
      return nxt;
   endfunction

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic             sqrt_q;
   logic [LANES-1:0] en_q;
   logic [LANES-1:0] sticky_q;
   logic [LANES-1:0] nz;
   lane_t            lane_q    [LANES];
   lane_t            lane_nxt  [LANES];
   lane_t            lane_load [LANES];
   logic             accept;
   logic             iter_en;
   logic             last;
   logic             term;

   assign accept  = (state == S_IDLE) && io.in_vld && !rtu_yy_xx_flush;
   assign iter_en = (state == S_ITER) && !rtu_yy_xx_flush;
   assign last    = (cnt == LAST);

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      nz = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_nxt[i]  = lane_step(sqrt_q, lane_q[i]);
         // sqrt remainder only counts as exhausted once the radicand bits are gone too
         nz[i]        = en_q[i] & ((|lane_nxt[i].rem) | (sqrt_q & (|lane_nxt[i].opnd)));
         lane_load[i] = '0;
         if (io.in_lane_en[i]) begin
            if (io.in_sqrt) begin
               lane_load[i].opnd = io.in_odd[i] ? {io.in_src_a[i*WIDTH +: WIDTH], 2'b00}
                                                : {1'b0, io.in_src_a[i*WIDTH +: WIDTH], 1'b0};
            end else begin
               lane_load[i].rem  = RW'(io.in_src_a[i*WIDTH +: WIDTH]);
               lane_load[i].opnd = QW'(io.in_src_b[i*WIDTH +: WIDTH]);
            end
         end
      end
   end

`ifdef CT_VFDSU_EARLY_TERM_EN
   assign term = ~|nz;
`else
   assign term = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_ITER;
         S_ITER:  if (rtu_yy_xx_flush) state_nxt = S_IDLE;
                  else if (last || term) state_nxt = S_DONE;
         S_DONE:  if (rtu_yy_xx_flush || io.out_ack) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) state <= S_IDLE;
      else           state <= state_nxt;
   end

   // NOTE: the lane registers are reset as well, because out_quo and out_sticky read them directly.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cnt      <= '0;
         sqrt_q   <= 1'b0;
         en_q     <= '0;
         sticky_q <= '0;
         for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      end else if (accept) begin
         cnt      <= '0;
         sqrt_q   <= io.in_sqrt;
         en_q     <= io.in_lane_en;
         sticky_q <= '0;
         for (int i = 0; i < LANES; i++) lane_q[i] <= lane_load[i];
      end else if (iter_en) begin
         cnt      <= cnt + 1'b1;
         sticky_q <= nz;
         for (int i = 0; i < LANES; i++) begin
            if (en_q[i]) begin
               lane_q[i] <= lane_nxt[i];
`ifdef CT_VFDSU_EARLY_TERM_EN
               if (term) lane_q[i].quo <= lane_nxt[i].quo << (LAST - cnt);
`endif
            end
         end
      end
   end

   assign io.in_rdy     = (state == S_IDLE);
   assign io.busy       = (state != S_IDLE);
   assign io.out_vld    = (state == S_DONE);
   assign io.out_sticky = sticky_q;

   always_comb begin
      io.out_quo = '0;
      for (int i = 0; i < LANES; i++) io.out_quo[i*QW +: QW] = lane_q[i].quo;
   end
endmodule
